// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready handshake.
// The carry chain is cut into STAGES slices; operands and partial sums travel in skew registers.
module add_sub_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int S = WIDTH / STAGES;

    logic             vld_q   [STAGES];
    logic             vld_d   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic             zero_q;
    logic             zero_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             msb_cin_s;
    logic             advance_s;

    // The whole pipeline moves as one; bubbles are never collapsed.
    assign advance_s = !vld_q[STAGES-1] || out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in_s;
        logic [WIDTH-1:0] a_in_s;
        logic [WIDTH-1:0] b_in_s;
        logic [WIDTH-1:0] s_in_s;
        logic             c_in_s;
        logic [S:0]       slice_s;
        logic [WIDTH-1:0] s_next_s;

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1, so B is inverted once on entry.
            assign v_in_s = in_valid;
            assign a_in_s = a;
            assign b_in_s = sub ? ~b : b;
            assign c_in_s = sub ? 1'b1 : cin;
            assign s_in_s = {WIDTH{1'b0}};
        end else begin : g_next
            assign v_in_s = vld_q[k-1];
            assign a_in_s = a_q[k-1];
            assign b_in_s = b_q[k-1];
            assign c_in_s = carry_q[k-1];
            assign s_in_s = sum_q[k-1];
        end

        assign slice_s = {1'b0, a_in_s[k*S +: S]} + {1'b0, b_in_s[k*S +: S]}
                       + {{S{1'b0}}, c_in_s};

        // Merge this stage's slice into the partial sum carried from upstream.
        always_comb begin
            s_next_s            = s_in_s;
            s_next_s[k*S +: S]  = slice_s[S-1:0];
        end

        assign vld_d[k]   = v_in_s;
        assign a_d[k]     = a_in_s;
        assign b_d[k]     = b_in_s;
        assign sum_d[k]   = s_next_s;
        assign carry_d[k] = slice_s[S];

        if (k == STAGES - 1) begin : g_last
            // Carry into the MSB recovered from the MSB's own sum bit.
            assign msb_cin_s = a_in_s[WIDTH-1] ^ b_in_s[WIDTH-1] ^ s_next_s[WIDTH-1];
        end
    end

    assign zero_d = (sum_d[STAGES-1] == {WIDTH{1'b0}});
    assign ovf_d  = msb_cin_s ^ carry_d[STAGES-1];

    // Stage registers; data only loads behind a valid so outputs stay zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k]   <= 1'b0;
                a_q[k]     <= {WIDTH{1'b0}};
                b_q[k]     <= {WIDTH{1'b0}};
                sum_q[k]   <= {WIDTH{1'b0}};
                carry_q[k] <= 1'b0;
            end
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (advance_s) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                if (vld_d[k]) begin
                    a_q[k]     <= a_d[k];
                    b_q[k]     <= b_d[k];
                    sum_q[k]   <= sum_d[k];
                    carry_q[k] <= carry_d[k];
                end
            end
            if (vld_d[STAGES-1]) begin
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign in_ready  = advance_s;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe: main 8/2 instance plus 16/4 and 8/1 sweep instances.
module tb_add_sub_pipe;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       z;
        logic       o;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, zero, ovf;
    logic [7:0] a, b, sum;

    logic        x16_in_valid, x16_in_ready, x16_cin, x16_sub, x16_out_valid, x16_cout, x16_zero, x16_ovf;
    logic [15:0] x16_a, x16_b, x16_sum;

    logic       x1_in_valid, x1_in_ready, x1_cin, x1_sub, x1_out_valid, x1_cout, x1_zero, x1_ovf;
    logic [7:0] x1_a, x1_b, x1_sum;

    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    res_t exp_r;
    res_t q[$];

    add_sub_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .zero(zero), .ovf(ovf)
    );

    add_sub_pipe #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(x16_in_valid), .in_ready(x16_in_ready),
        .a(x16_a), .b(x16_b), .cin(x16_cin), .sub(x16_sub), .out_valid(x16_out_valid),
        .out_ready(1'b1), .sum(x16_sum), .cout(x16_cout), .zero(x16_zero), .ovf(x16_ovf)
    );

    add_sub_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(x1_in_valid), .in_ready(x1_in_ready),
        .a(x1_a), .b(x1_b), .cin(x1_cin), .sub(x1_sub), .out_valid(x1_out_valid),
        .out_ready(1'b1), .sum(x1_sum), .cout(x1_cout), .zero(x1_zero), .ovf(x1_ovf)
    );

    function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic mc, input logic ms);
        logic [7:0] bx;
        logic [8:0] t;
        res_t       r;
        bx  = ms ? ~mb : mb;
        t   = {1'b0, ma} + {1'b0, bx} + {8'd0, (ms ? 1'b1 : mc)};
        r.s = t[7:0];
        r.c = t[8];
        r.z = (t[7:0] == 8'd0);
        r.o = (ma[7] == bx[7]) && (t[7] != ma[7]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Scoreboard: mid-cycle sampling of the transfer that will happen on the next edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (in_valid && in_ready) q.push_back(exp_r);
            if (out_valid && out_ready) begin
                checks++;
                pops++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got sum=%h c=%b z=%b o=%b expected no output",
                             sum, cout, zero, ovf);
                end else begin
                    res_t r;
                    r = q.pop_front();
                    if ({sum, cout, zero, ovf} !== r) begin
                        failures++;
                        $display("FAIL sb_result got sum=%h c=%b z=%b o=%b expected sum=%h c=%b z=%b o=%b",
                                 sum, cout, zero, ovf, r.s, r.c, r.z, r.o);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic ts, input res_t e);
        @(posedge clk); #1;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; exp_r = e;
    endtask

    task automatic send_rand();
        logic [7:0] ra, rb;
        logic       rc, rs;
        ra = 8'($urandom); rb = 8'($urandom);
        rc = 1'($urandom); rs = 1'($urandom);
        send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'd0);
        chk({tag, "_flags"}, 32'({cout, zero, ovf}), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic x16_run(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                           input logic [15:0] es, input logic ec, input logic eo);
        @(posedge clk); #1;
        x16_a = ta; x16_b = tb; x16_cin = 1'b0; x16_sub = ts; x16_in_valid = 1'b1;
        @(posedge clk); #1;
        x16_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("x16_latency_early", 32'(x16_out_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("x16_out_valid", 32'(x16_out_valid), 32'd1);
        chk("x16_sum", 32'(x16_sum), 32'(es));
        chk("x16_cout_ovf", 32'({x16_cout, x16_ovf}), 32'({ec, eo}));
    endtask

    task automatic x1_run(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic ts, input res_t e);
        @(posedge clk); #1;
        x1_a = ta; x1_b = tb; x1_cin = tc; x1_sub = ts; x1_in_valid = 1'b1;
        @(posedge clk); #1;
        x1_in_valid = 1'b0;
        chk("x1_out_valid", 32'(x1_out_valid), 32'd1);
        chk("x1_result", 32'({x1_sum, x1_cout, x1_zero, x1_ovf}), 32'(e));
    endtask

    initial begin
        int   p0;
        res_t snap;
        logic snap_v;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'd0; b = 8'd0; cin = 1'b0; sub = 1'b0; exp_r = '0;
        x16_in_valid = 1'b0; x16_a = 16'd0; x16_b = 16'd0; x16_cin = 1'b0; x16_sub = 1'b0;
        x1_in_valid = 1'b0; x1_a = 8'd0; x1_b = 8'd0; x1_cin = 1'b0; x1_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        // Latency of 2 edges on the first directed add.
        send(8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b0, 1'b1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_early_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_sum", 32'(sum), 32'h80);

        send(8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b0});
        send(8'h05, 8'h07, 1'b1, 1'b1, '{8'hFE, 1'b0, 1'b0, 1'b0});
        send(8'h80, 8'h01, 1'b0, 1'b1, '{8'h7F, 1'b1, 1'b0, 1'b1});
        idle(3);

        // Back-to-back stream of 16.
        p0 = pops;
        for (int i = 0; i < 16; i++) send_rand();
        idle(2);
        @(negedge clk); #1;
        chk("stream_count", 32'(pops - p0), 32'd16);

        // Backpressure: fill, stall 5 cycles, release.
        p0 = pops;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h10, 8'h20, 1'b0, 1'b0, '{8'h30, 1'b0, 1'b0, 1'b0});
        send(8'h00, 8'h01, 1'b0, 1'b1, '{8'hFF, 1'b0, 1'b0, 1'b0});
        send(8'h40, 8'h40, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b0, 1'b1});
        snap   = '{sum, cout, zero, ovf};
        snap_v = out_valid;
        chk("bp_full_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'({out_valid, sum, cout, zero, ovf}), 32'({snap_v, snap}));
        end
        out_ready = 1'b1;
        idle(4);
        chk("bp_drain_count", 32'(pops - p0), 32'd3);

        // Random in_valid/out_ready toggling.
        for (int i = 0; i < 1000; i++) begin
            send_rand();
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
        end
        out_ready = 1'b1;
        idle(6);
        chk("random_drained", 32'(q.size()), 32'd0);

        // Reset with two transactions in flight.
        p0 = pops;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 1'b0, '{8'h33, 1'b0, 1'b0, 1'b0});
        send(8'h01, 8'h01, 1'b0, 1'b1, '{8'h00, 1'b1, 1'b1, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check_reset_state("midrst");
        idle(4);
        chk("midrst_no_output", 32'(pops - p0), 32'd0);

        // Parameter sweep instances.
        x16_run(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        x16_run(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        x1_run(8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b0, 1'b1});
        x1_run(8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b0});
        x1_run(8'h05, 8'h07, 1'b1, 1'b1, '{8'hFE, 1'b0, 1'b0, 1'b0});
        x1_run(8'h80, 8'h01, 1'b0, 1'b1, '{8'h7F, 1'b1, 1'b0, 1'b1});
        x1_run(8'h3C, 8'h0F, 1'b1, 1'b0, '{8'h4C, 1'b0, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
# add_sub_pipe

Parametrised, pipelined adder/subtractor: the next-generation arithmetic unit for the SAP datapath. It replaces the fixed 8-bit combinational ripple adder with a WIDTH-bit carry chain split across STAGES registered slices. It adds a subtract mode, signed/unsigned status flags and a valid/ready handshake, so the ALU can run at a higher clock rate and stall cleanly against the accumulator/bus.

## Interface
- WIDTH, 8: operand/result width in bits; must be divisible by STAGES.
- STAGES, 2: pipeline depth; the carry chain is cut into STAGES slices of WIDTH/STAGES bits each; 1 <= STAGES <= WIDTH.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands/mode present this cycle.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (for subtract: 1 = no borrow).
- zero  out  1  sum == 0.
- ovf  out  1  signed two's-complement overflow.

## Operation
- Add: sum = a + b + cin (mod 2^WIDTH).
- Subtract: sum = a + ~b + 1; cin is ignored.
- cout = carry out of bit WIDTH-1.
- ovf = carry into MSB XOR carry out of MSB.
- zero = (sum == 0), computed on the final result.
- Stage k (0-based) computes bits [k*S +: S], where S = WIDTH/STAGES, using the carry registered by stage k-1 (stage 0 uses cin or 1).
- Not-yet-consumed upper operand bits and already-computed lower sum bits travel with the transaction in skew registers.
- Each stage holds a valid bit. Global advance = !out_valid || out_ready. When advance=1, every stage shifts forward by one and stage 0 loads the input transaction (valid = in_valid).
- When advance=0, all stages hold their contents.
- in_ready = advance, combinational from out_valid/out_ready only, never from in_valid.
- A transfer occurs on in_valid && in_ready (input) and on out_valid && out_ready (output).
- Bubbles travel with the pipeline. Collapsing bubbles during a stall is not required and must not occur.
- Transaction order is preserved; no transaction is dropped or duplicated.

## Timing
- Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+STAGES-1. For STAGES=1 it is visible the cycle after acceptance, i.e. the output is registered.
- Throughput: one transaction per cycle while out_ready=1.
- While out_valid=1 and out_ready=0, sum/cout/zero/ovf/out_valid are held stable, and in_ready=0.
- Reset: on any rising edge with rst=1, all stage valid bits clear, and out_valid=0, sum=0, cout=0, zero=0, ovf=0. In-flight transactions are discarded. in_ready=1 in the first cycle after reset.
- rst has priority over in_valid and out_ready in the same cycle.
- Simultaneous output consume and input accept in the same cycle is legal and must lose nothing.
- Data outputs are don't-care when out_valid=0, except after reset, where they are 0.

## Test plan
- WIDTH=8, STAGES=2, add with out_ready=1:
  - a=0x7F, b=0x01, cin=0 -> after 2 edges sum=0x80, cout=0, zero=0, ovf=1.
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, zero=1, ovf=0.
- Subtract, with the cin check:
  - a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Back-to-back stream of 16 random add/sub transactions with out_ready=1 -> 16 results in order at one per cycle, each matching a reference model.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with the pipeline full -> in_ready=0; outputs stable and unchanged.
  - Release -> results drain in order with no loss or duplication.
  - Also cover random in_valid/out_ready toggling over 1000 cycles.
- Reset mid-flight: assert rst for 1 cycle with 2 transactions in the pipeline -> next cycle out_valid=0, sum=0, flags=0, in_ready=1; neither transaction ever appears.
- Parameter sweep:
  - WIDTH=16, STAGES=4: a=0x00FF, b=0x0001 -> sum=0x0100, carry crossing the slice boundary, latency 4.
  - WIDTH=8, STAGES=1: identical results to the 8-bit ripple adder with latency 1.
